cam_dvp_emitter: RTL

Camera-side transmitter for the OV7670 parallel (DVP) interface: pops 34-bit video beats from an async FIFO read port and serialises them as VSYNC/HREF/8-bit byte stream on PCLK with OV7670 VGA frame timing. It is the exact counterpart of the capture block's framing (`{pixel[15:0], 16'h0000, sof, eol}`, first byte = `pixel[7:0]`), used as a camera model in system benches and as an on-FPGA loopback source for bring-up without a sensor.

---
 rtl/cam_dvp_pkg.sv | 33 +++
 rtl/cam_dvp_timing.sv | 156 +++++++++++++++
 rtl/cam_dvp_emitter.sv | 104 ++++++++++
 3 files changed

// File: rtl/cam_dvp_pkg.sv
// Shared definitions for the DVP camera emitter: beat field positions, OV7670
// VGA timing defaults and the frame state encoding.
package cam_dvp_pkg;

    localparam int TDATA_W = 34;
    localparam int PIX_MSB = 33;
    localparam int PIX_LSB = 18;
    localparam int SOF_BIT = 1;
    localparam int EOL_BIT = 0;

    localparam int DEF_ACTIVE_W = 640;
    localparam int DEF_ACTIVE_H = 480;
    localparam int DEF_H_BLANK  = 288;
    localparam int DEF_VS_LINES = 3;
    localparam int DEF_VB_LINES = 17;
    localparam int DEF_VF_LINES = 10;
    localparam logic [15:0] DEF_FILL_PIX = 16'hF81F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_HACT   = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } dvp_state_t;

    // Every line period (sync, porch, active) is two bytes per pixel plus blanking.
    function automatic int line_tp(input int active_w, input int h_blank);
        return 2 * active_w + h_blank;
    endfunction

endpackage

// File: rtl/cam_dvp_timing.sv
// Frame/line sequencer for the DVP emitter: walks sync, porches and active lines,
// and tells the datapath when to pop a pixel and where that pixel sits.
module cam_dvp_timing
    import cam_dvp_pkg::*;
#(
    parameter int ACTIVE_W = DEF_ACTIVE_W,
    parameter int ACTIVE_H = DEF_ACTIVE_H,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int VS_LINES = DEF_VS_LINES,
    parameter int VB_LINES = DEF_VB_LINES,
    parameter int VF_LINES = DEF_VF_LINES
) (
    input  logic                        i_pclk,
    input  logic                        i_rstn,
    input  logic                        i_en,
    output logic                        o_vsync,
    output logic                        o_href,
    output logic                        o_status,
    output logic                        o_pix_pop,
    output logic                        o_lock_win,
    output logic [$clog2(ACTIVE_W)-1:0] o_pop_x,
    output logic [$clog2(ACTIVE_H)-1:0] o_pop_y
);
    localparam int LINE_TP = line_tp(ACTIVE_W, H_BLANK);
    localparam int CW = $clog2(LINE_TP);
    localparam int LW = $clog2(VS_LINES + VB_LINES + VF_LINES + 1);
    localparam int XW = $clog2(ACTIVE_W);
    localparam int YW = $clog2(ACTIVE_H);

    localparam logic [CW-1:0] CNT_LINE_END = CW'(LINE_TP - 1);
    localparam logic [CW-1:0] CNT_HACT_END = CW'(2 * ACTIVE_W - 1);
    localparam logic [CW-1:0] CNT_HB_END   = CW'(H_BLANK - 1);
    localparam logic [LW-1:0] VS_LAST      = LW'(VS_LINES - 1);
    localparam logic [LW-1:0] VB_LAST      = LW'(VB_LINES - 1);
    localparam logic [LW-1:0] VF_LAST      = LW'(VF_LINES - 1);
    localparam logic [YW-1:0] Y_LAST       = YW'(ACTIVE_H - 1);

    dvp_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [LW-1:0] line_reg, line_next;
    logic [YW-1:0] y_reg, y_next;
    logic          vsync_reg, vsync_next;
    logic          href_reg, href_next;
    logic          status_reg, status_next;

    always_ff @(posedge i_pclk) begin
        if (!i_rstn) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            line_reg   <= '0;
            y_reg      <= '0;
            vsync_reg  <= 1'b0;
            href_reg   <= 1'b0;
            status_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            line_reg   <= line_next;
            y_reg      <= y_next;
            vsync_reg  <= vsync_next;
            href_reg   <= href_next;
            status_reg <= status_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CW'(1);
        line_next  = line_reg;
        y_next     = y_reg;
        unique case (state_reg)
            ST_IDLE: begin
                cnt_next  = '0;
                line_next = '0;
                y_next    = '0;
                if (i_en) state_next = ST_VSYNC;
            end
            ST_VSYNC: if (cnt_reg == CNT_LINE_END) begin
                cnt_next  = '0;
                line_next = line_reg + LW'(1);
                if (line_reg == VS_LAST) begin
                    line_next  = '0;
                    state_next = ST_VBACK;
                end
            end
            ST_VBACK: if (cnt_reg == CNT_LINE_END) begin
                cnt_next  = '0;
                line_next = line_reg + LW'(1);
                if (line_reg == VB_LAST) begin
                    line_next  = '0;
                    y_next     = '0;
                    state_next = ST_HACT;
                end
            end
            ST_HACT: if (cnt_reg == CNT_HACT_END) begin
                cnt_next   = '0;
                state_next = ST_HBLANK;
            end
            ST_HBLANK: if (cnt_reg == CNT_HB_END) begin
                cnt_next = '0;
                if (y_reg == Y_LAST) begin
                    y_next     = '0;
                    state_next = ST_VFRONT;
                end else begin
                    y_next     = y_reg + YW'(1);
                    state_next = ST_HACT;
                end
            end
            ST_VFRONT: if (cnt_reg == CNT_LINE_END) begin
                cnt_next  = '0;
                line_next = line_reg + LW'(1);
                if (line_reg == VF_LAST) begin
                    line_next  = '0;
                    state_next = i_en ? ST_VSYNC : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A pixel is popped one cycle ahead of its low byte, so the first pop of a
    // line lands on the last cycle of the preceding porch or blanking interval.
    always_comb begin
        vsync_next  = (state_next == ST_VSYNC);
        href_next   = (state_next == ST_HACT);
        status_next = (state_next != ST_IDLE);
        o_pix_pop   = 1'b0;
        o_lock_win  = 1'b0;
        o_pop_x     = '0;
        o_pop_y     = y_reg;
        unique case (state_reg)
            ST_VBACK: begin
                if (cnt_reg == CNT_LINE_END && line_reg == VB_LAST) begin
                    o_pix_pop = 1'b1;
                    o_pop_y   = '0;
                end else begin
                    o_lock_win = 1'b1;
                end
            end
            ST_HACT: if (cnt_reg[0] && cnt_reg != CNT_HACT_END) begin
                o_pix_pop = 1'b1;
                o_pop_x   = XW'((cnt_reg + CW'(1)) >> 1);
            end
            ST_HBLANK: if (cnt_reg == CNT_HB_END && y_reg != Y_LAST) begin
                o_pix_pop = 1'b1;
                o_pop_y   = y_reg + YW'(1);
            end
            default: ;
        endcase
    end

    assign o_vsync  = vsync_reg;
    assign o_href   = href_reg;
    assign o_status = status_reg;

endmodule

// File: rtl/cam_dvp_emitter.sv
// OV7670-style DVP transmitter: pops framed video beats and serialises each
// pixel as low byte then high byte, with frame lock and sticky error flags.
module cam_dvp_emitter
    import cam_dvp_pkg::*;
#(
    parameter int          ACTIVE_W = DEF_ACTIVE_W,
    parameter int          ACTIVE_H = DEF_ACTIVE_H,
    parameter int          H_BLANK  = DEF_H_BLANK,
    parameter int          VS_LINES = DEF_VS_LINES,
    parameter int          VB_LINES = DEF_VB_LINES,
    parameter int          VF_LINES = DEF_VF_LINES,
    parameter logic [15:0] FILL_PIX = DEF_FILL_PIX
) (
    input  logic               i_pclk,
    input  logic               i_rstn,
    input  logic               i_en,
    input  logic               i_svalid,
    input  logic [TDATA_W-1:0] i_tdata,
    output logic               o_sready,
    output logic               o_vsync,
    output logic               o_href,
    output logic [7:0]         o_data,
    output logic               o_underflow,
    output logic               o_desync,
    output logic               o_status
);
    localparam int XW = $clog2(ACTIVE_W);
    localparam int YW = $clog2(ACTIVE_H);

    logic          pix_pop;
    logic          lock_win;
    logic [XW-1:0] pop_x;
    logic [YW-1:0] pop_y;

    cam_dvp_timing #(
        .ACTIVE_W (ACTIVE_W),
        .ACTIVE_H (ACTIVE_H),
        .H_BLANK  (H_BLANK),
        .VS_LINES (VS_LINES),
        .VB_LINES (VB_LINES),
        .VF_LINES (VF_LINES)
    ) u_timing (
        .i_pclk     (i_pclk),
        .i_rstn     (i_rstn),
        .i_en       (i_en),
        .o_vsync    (o_vsync),
        .o_href     (o_href),
        .o_status   (o_status),
        .o_pix_pop  (pix_pop),
        .o_lock_win (lock_win),
        .o_pop_x    (pop_x),
        .o_pop_y    (pop_y)
    );

    logic [15:0] pix_in;
    logic        pos_err;
    logic        unused_bits;

    assign pix_in      = i_svalid ? i_tdata[PIX_MSB:PIX_LSB] : FILL_PIX;
    assign unused_bits = ^i_tdata[PIX_LSB-1:SOF_BIT+1];

    // Before the frame starts, non-sof beats are discarded so the frame always
    // opens on a sof beat; a sof beat is left in place for the first pixel pop.
    assign o_sready = pix_pop | (lock_win & ~i_tdata[SOF_BIT]);

    assign pos_err = (i_tdata[SOF_BIT] != ((pop_x == '0) && (pop_y == '0)))
                   | (i_tdata[EOL_BIT] != (pop_x == XW'(ACTIVE_W - 1)));

    logic [7:0] data_reg;
    logic [7:0] hi_reg;
    logic       hi_pend_reg;
    logic       underflow_reg;
    logic       desync_reg;

    always_ff @(posedge i_pclk) begin
        if (!i_rstn) begin
            data_reg      <= '0;
            hi_reg        <= '0;
            hi_pend_reg   <= 1'b0;
            underflow_reg <= 1'b0;
            desync_reg    <= 1'b0;
        end else begin
            if (pix_pop) begin
                data_reg    <= pix_in[7:0];
                hi_reg      <= pix_in[15:8];
                hi_pend_reg <= 1'b1;
            end else if (hi_pend_reg) begin
                data_reg    <= hi_reg;
                hi_pend_reg <= 1'b0;
            end else begin
                data_reg    <= '0;
            end
            if (pix_pop && !i_svalid)
                underflow_reg <= 1'b1;
            if (pix_pop && i_svalid && pos_err)
                desync_reg <= 1'b1;
        end
    end

    assign o_data      = data_reg;
    assign o_underflow = underflow_reg;
    assign o_desync    = desync_reg;

endmodule
